// File: rtl/shiftin_rx_pkg.sv
// Shared definitions for the serial shift-register receiver: frame width and
// default synchroniser depth, kept in step with the shiftout transmitter.
package shiftin_rx_pkg;

  localparam int DAC_WORD_WIDTH  = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Counter must reach WIDTH+1 ("too many bits") without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/shiftin_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with a rising-edge strobe
// taken from one extra flop after the chain.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/shiftin_rx.sv
// Receiver for the ser/sclk/lclk shift-register protocol: assembles WIDTH-bit
// words MSB first and presents each on the lclk latch edge, flagging bad frames.
module shiftin_rx
  import shiftin_rx_pkg::*;
#(
  parameter int WIDTH       = DAC_WORD_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             ser_i,
  input  logic             sclk_i,
  input  logic             lclk_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_rdy_o,
  output logic             frame_err_o
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  // Asynchronous assertion, deassertion released on clk_i.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic ser_sync, ser_rise;
  logic sclk_lvl, sclk_rise;
  logic lclk_lvl, lclk_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_ser  (.clk_i(clk_i), .reset_ni(rst_n), .d_i(ser_i),
                                            .q_o(ser_sync), .rise_o(ser_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk_i(clk_i), .reset_ni(rst_n), .d_i(sclk_i),
                                            .q_o(sclk_lvl), .rise_o(sclk_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_lclk (.clk_i(clk_i), .reset_ni(rst_n), .d_i(lclk_i),
                                            .q_o(lclk_lvl), .rise_o(lclk_rise));

  logic unused_sigs;
  assign unused_sigs = ^{ser_rise, sclk_lvl, lclk_lvl};

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  // The shift is evaluated first so a coincident latch sees the new bit.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    if (sclk_rise) begin
      shreg_d = {shreg_q[WIDTH-2:0], ser_sync};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
    if (lclk_rise) begin
      if (cnt_d == CNT_FULL) begin
        data_d = shreg_d;
        rdy_d  = 1'b1;
      end else begin
        err_d  = 1'b1;
      end
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign data_o      = data_q;
  assign data_rdy_o  = rdy_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_shiftin_rx.sv
// Directed and randomized frames against a bit-queue reference model of the
// shift-register receive protocol.
module tb_shiftin_rx;

  localparam int W   = 16;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic         clk_i    = 1'b0;
  logic         reset_ni = 1'b1;
  logic         ser_i    = 1'b0;
  logic         sclk_i   = 1'b0;
  logic         lclk_i   = 1'b0;
  logic [W-1:0] data_o;
  logic         data_rdy_o;
  logic         frame_err_o;

  int           total = 0;
  int           bad   = 0;
  bit           mq[$];
  logic [W-1:0] exp_data = '0;

  shiftin_rx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .ser_i(ser_i), .sclk_i(sclk_i),
    .lclk_i(lclk_i), .data_o(data_o), .data_rdy_o(data_rdy_o), .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // One bit: data setup for h cycles with sclk low, then sclk high for h cycles.
  task automatic send_bit(input bit b, input int h);
    ser_i = b;
    cyc(h);
    sclk_i = 1'b1;
    mq.push_back(b);
    cyc(h);
    sclk_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v, input int n, input int h);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], h);
  endtask

  // Latch the frame; optionally the last bit's sclk rises together with lclk.
  task automatic latch(input string tag, input int h, input bit last_en, input bit last_b);
    int           rdy_n = 0;
    int           err_n = 0;
    int           first = -1;
    bit           ok;
    logic [W-1:0] w;
    logic [W-1:0] seen;
    if (last_en) begin
      ser_i = last_b;
      cyc(h);
      sclk_i = 1'b1;
      mq.push_back(last_b);
    end
    lclk_i = 1'b1;
    ok = (mq.size() == W);
    if (ok) begin
      w = '0;
      foreach (mq[i]) w = W'((w * 2) + mq[i]);
      exp_data = w;
    end
    mq.delete();
    seen = data_o;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      if (k == h) begin
        lclk_i = 1'b0;
        sclk_i = 1'b0;
      end
      if (first < 0 && (data_rdy_o === 1'b1 || frame_err_o === 1'b1)) first = k;
      if (data_rdy_o === 1'b1) seen = data_o;
      rdy_n += int'(data_rdy_o === 1'b1);
      err_n += int'(frame_err_o === 1'b1);
    end
    check({tag, ".rdy_pulses"}, rdy_n, ok ? 1 : 0);
    check({tag, ".err_pulses"}, err_n, ok ? 0 : 1);
    check({tag, ".latency"}, first, LAT);
    check({tag, ".data_at_rdy"}, seen, exp_data);
    check({tag, ".data_after"}, data_o, exp_data);
  endtask

  initial begin
    logic [15:0] r;
    int          n;
    int          h;

    #1 reset_ni = 1'b0;
    cyc(3);
    check("reset.data", data_o, 0);
    check("reset.rdy", data_rdy_o, 0);
    check("reset.err", frame_err_o, 0);
    reset_ni = 1'b1;
    cyc(4);

    send_word(32'hA5C3, 16, 3);
    latch("t1_a5c3", 3, 1'b0, 1'b0);

    r = 16'($urandom);
    send_word({16'h0, r}, 12, 4);
    latch("t2_short", 4, 1'b0, 1'b0);
    send_word($urandom, 20, 3);
    latch("t2_long", 3, 1'b0, 1'b0);
    latch("t2_empty", 3, 1'b0, 1'b0);

    send_word(32'h0001, 16, 3);
    latch("t3_0001", 3, 1'b0, 1'b0);
    send_word(32'hFFFF, 16, 3);
    latch("t3_ffff", 3, 1'b0, 1'b0);
    send_word(32'h8000, 16, 3);
    latch("t3_8000", 3, 1'b0, 1'b0);

    r = 16'($urandom);
    send_word({17'h0, r[15:1]}, 15, 3);
    latch("t4_coincident", 3, 1'b1, r[0]);

    send_word(32'h3FFF, 16, 4);
    latch("t6_loopback", 4, 1'b0, 1'b0);

    send_word(32'h0012, 8, 3);
    reset_ni = 1'b0;
    #1;
    check("t5_rst.data", data_o, 0);
    check("t5_rst.rdy", data_rdy_o, 0);
    check("t5_rst.err", frame_err_o, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    mq.delete();
    exp_data = '0;
    cyc(4);
    check("t5_post.data", data_o, 0);
    send_word(32'hBEEF, 16, 3);
    latch("t5_beef", 3, 1'b0, 1'b0);

    for (int f = 0; f < 10; f++) begin
      h = 3 + int'($urandom_range(0, 2));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : W;
      send_word($urandom, n, h);
      latch($sformatf("rnd%0d_n%0d", f, n), h, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
